// File: rtl/c2h_arb_pkg.sv
// Shared types and helpers for the C2H stream arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package c2h_arb_pkg;

    // Width of the packets-per-interrupt counter.
    localparam int IRQ_CNT_W = 16;

    // Two-state transfer FSM: waiting for a request, or moving one packet.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_t;

    // Grant index width. A single-source build still gets one index bit.
    function automatic int src_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/c2h_stream_arbiter_rr_arbiter.sv
// Round-robin picker: first requester strictly after 'last', wrapping modulo NUM_SRC.
// Latency: purely combinational, result valid in the same cycle as req.
// Backpressure: none; the caller decides when to act on gnt_idx/gnt_vld.
module rr_arbiter
    import c2h_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = src_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   last,
    output logic [SRC_W-1:0]   gnt_idx,
    output logic               gnt_vld
);

    logic [SRC_W-1:0] cand;

    // Walk offsets 1..NUM_SRC from the last winner; the first hit wins, so the
    // last winner itself is considered only after everyone else.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = SRC_W'((int'(last) + k) % NUM_SRC);
            if (!gnt_vld && req[cand]) begin
                gnt_idx = cand;
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/c2h_stream_arbiter.sv
// Packet-granular round-robin mux of NUM_SRC AXI-stream sources onto the XDMA C2H stream, with packet-count interrupts.
// Latency: 1 idle arbitration cycle before each packet, then zero-cycle combinational pass-through of every beat.
// Backpressure: m_axis_c2h_tready is routed straight to the granted source's tready; all other sources see tready=0.
module c2h_stream_arbiter
    import c2h_arb_pkg::*;
#(
    parameter int NUM_SRC         = 4,
    parameter int DATA_WIDTH      = 128,
    parameter int BYTE_BIT_ENABLE = DATA_WIDTH / 8,
    parameter int IRQ_WIDTH       = 1,
    parameter int IRQ_PKT_CNT     = 1,
    parameter int SRC_W           = src_w(NUM_SRC)
) (
    input  logic                                 user_clk,
    input  logic                                 user_rst,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]        s_axis_tdata,
    input  logic [NUM_SRC*BYTE_BIT_ENABLE-1:0]   s_axis_tkeep,
    input  logic [NUM_SRC-1:0]                   s_axis_tlast,
    input  logic [NUM_SRC-1:0]                   s_axis_tvalid,
    output logic [NUM_SRC-1:0]                   s_axis_tready,
    output logic [DATA_WIDTH-1:0]                m_axis_c2h_tdata,
    output logic [BYTE_BIT_ENABLE-1:0]           m_axis_c2h_tkeep,
    output logic                                 m_axis_c2h_tlast,
    output logic                                 m_axis_c2h_tvalid,
    input  logic                                 m_axis_c2h_tready,
    output logic [SRC_W-1:0]                     grant_id,
    output logic                                 busy,
    output logic [IRQ_WIDTH-1:0]                 irq_req,
    input  logic [IRQ_WIDTH-1:0]                 irq_ack,
    output logic [31:0]                          pkt_count
);

    localparam logic [IRQ_CNT_W-1:0] IRQ_THR = IRQ_CNT_W'(IRQ_PKT_CNT);

    arb_state_t            state;
    arb_state_t            state_nxt;
    logic [SRC_W-1:0]      last_grant;
    logic [SRC_W-1:0]      pick_idx;
    logic                  pick_vld;
    logic                  beat;
    logic                  last_beat;
    logic [IRQ_CNT_W-1:0]  irq_cnt;
    logic [IRQ_CNT_W-1:0]  irq_cnt_inc;
    logic                  irq_thr_hit;
    logic                  irq_q;
    logic                  unused_irq_ack;

    // Only bit 0 of the ack vector means anything; the rest is tied off here.
    assign unused_irq_ack = ^irq_ack;

    assign busy = (state == ST_XFER);

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_rr_arbiter (
        .req     (s_axis_tvalid),
        .last    (last_grant),
        .gnt_idx (pick_idx),
        .gnt_vld (pick_vld)
    );

    // State register; reset abandons any packet in flight.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath mux, handshake decode and next state. Everything is zero in IDLE.
    always_comb begin
        m_axis_c2h_tdata  = '0;
        m_axis_c2h_tkeep  = '0;
        m_axis_c2h_tlast  = 1'b0;
        m_axis_c2h_tvalid = 1'b0;
        s_axis_tready     = '0;
        state_nxt         = state;
        if (state == ST_XFER) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (grant_id == SRC_W'(i)) begin
                    m_axis_c2h_tdata  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                    m_axis_c2h_tkeep  = s_axis_tkeep[i*BYTE_BIT_ENABLE +: BYTE_BIT_ENABLE];
                    m_axis_c2h_tlast  = s_axis_tlast[i];
                    m_axis_c2h_tvalid = s_axis_tvalid[i];
                    s_axis_tready[i]  = m_axis_c2h_tready;
                end
            end
        end
        beat      = m_axis_c2h_tvalid & m_axis_c2h_tready;
        last_beat = beat & m_axis_c2h_tlast;
        case (state)
            ST_IDLE: if (pick_vld)  state_nxt = ST_XFER;
            ST_XFER: if (last_beat) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    // Latch the winner when leaving IDLE; remember it as the round-robin pointer at packet end.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            grant_id   <= '0;
            last_grant <= SRC_W'(NUM_SRC - 1);
        end else begin
            if (state == ST_IDLE && pick_vld) begin
                grant_id <= pick_idx;
            end
            if (last_beat) begin
                last_grant <= grant_id;
            end
        end
    end

    // Free-running completed-packet counter, wraps naturally at 2^32.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            pkt_count <= '0;
        end else if (last_beat) begin
            pkt_count <= pkt_count + 32'd1;
        end
    end

    assign irq_cnt_inc = irq_cnt + IRQ_CNT_W'(1);
    assign irq_thr_hit = last_beat && (irq_cnt_inc == IRQ_THR);

    // Interrupt request: a new threshold event beats a simultaneous ack, and
    // events while already pending simply keep the request high.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            irq_cnt <= '0;
            irq_q   <= 1'b0;
        end else begin
            if (irq_thr_hit) begin
                irq_cnt <= '0;
            end else if (last_beat) begin
                irq_cnt <= irq_cnt_inc;
            end
            if (irq_thr_hit) begin
                irq_q <= 1'b1;
            end else if (irq_ack[0]) begin
                irq_q <= 1'b0;
            end
        end
    end

    // Upper request bits are permanently low.
    always_comb begin
        irq_req    = '0;
        irq_req[0] = irq_q;
    end

endmodule

// File: tb/tb_c2h_stream_arbiter.sv
module tb_c2h_stream_arbiter;

    logic          user_clk = 1'b0;
    logic          user_rst;
    logic [511:0]  s_axis_tdata;
    logic [63:0]   s_axis_tkeep;
    logic [3:0]    s_axis_tlast;
    logic [3:0]    s_axis_tvalid;
    logic          m_axis_c2h_tready;

    // Instance with default parameters (one interrupt per packet).
    wire  [3:0]    s_axis_tready;
    wire  [127:0]  m_axis_c2h_tdata;
    wire  [15:0]   m_axis_c2h_tkeep;
    wire           m_axis_c2h_tlast;
    wire           m_axis_c2h_tvalid;
    wire  [1:0]    grant_id;
    wire           busy;
    wire  [0:0]    irq_req;
    logic [0:0]    irq_ack;
    wire  [31:0]   pkt_count;

    // Second instance: interrupt every 3 packets, 2-bit irq vectors.
    wire  [3:0]    s_axis_tready3;
    wire  [127:0]  m_axis_c2h_tdata3;
    wire  [15:0]   m_axis_c2h_tkeep3;
    wire           m_axis_c2h_tlast3;
    wire           m_axis_c2h_tvalid3;
    wire  [1:0]    grant_id3;
    wire           busy3;
    wire  [1:0]    irq_req3;
    logic [1:0]    irq_ack3;
    wire  [31:0]   pkt_count3;

    int checks = 0;
    int errors = 0;

    always #5 user_clk = ~user_clk;

    c2h_stream_arbiter #(
        .NUM_SRC(4), .DATA_WIDTH(128), .BYTE_BIT_ENABLE(16), .IRQ_WIDTH(1), .IRQ_PKT_CNT(1)
    ) dut (
        .user_clk          (user_clk),
        .user_rst          (user_rst),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tkeep      (s_axis_tkeep),
        .s_axis_tlast      (s_axis_tlast),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tready     (s_axis_tready),
        .m_axis_c2h_tdata  (m_axis_c2h_tdata),
        .m_axis_c2h_tkeep  (m_axis_c2h_tkeep),
        .m_axis_c2h_tlast  (m_axis_c2h_tlast),
        .m_axis_c2h_tvalid (m_axis_c2h_tvalid),
        .m_axis_c2h_tready (m_axis_c2h_tready),
        .grant_id          (grant_id),
        .busy              (busy),
        .irq_req           (irq_req),
        .irq_ack           (irq_ack),
        .pkt_count         (pkt_count)
    );

    c2h_stream_arbiter #(
        .NUM_SRC(4), .DATA_WIDTH(128), .BYTE_BIT_ENABLE(16), .IRQ_WIDTH(2), .IRQ_PKT_CNT(3)
    ) dut3 (
        .user_clk          (user_clk),
        .user_rst          (user_rst),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tkeep      (s_axis_tkeep),
        .s_axis_tlast      (s_axis_tlast),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tready     (s_axis_tready3),
        .m_axis_c2h_tdata  (m_axis_c2h_tdata3),
        .m_axis_c2h_tkeep  (m_axis_c2h_tkeep3),
        .m_axis_c2h_tlast  (m_axis_c2h_tlast3),
        .m_axis_c2h_tvalid (m_axis_c2h_tvalid3),
        .m_axis_c2h_tready (m_axis_c2h_tready),
        .grant_id          (grant_id3),
        .busy              (busy3),
        .irq_req           (irq_req3),
        .irq_ack           (irq_ack3),
        .pkt_count         (pkt_count3)
    );

    function automatic logic [127:0] mk_dat(input int s, input int b);
        return {32'hC0DE_0000 | 32'(s), 32'(b), 64'h0123_4567_89AB_CDEF};
    endfunction

    function automatic logic [15:0] mk_keep(input int s);
        return 16'hFFFF >> s;
    endfunction

    task automatic set_src(input int s, input logic v, input logic l, input logic [127:0] d);
        s_axis_tvalid[s]          = v;
        s_axis_tlast[s]           = l;
        s_axis_tdata[s*128 +: 128] = d;
        s_axis_tkeep[s*16 +: 16]   = v ? mk_keep(s) : 16'h0;
    endtask

    task automatic do_reset;
        @(negedge user_clk);
        user_rst          = 1'b1;
        s_axis_tvalid     = '0;
        s_axis_tlast      = '0;
        s_axis_tdata      = '0;
        s_axis_tkeep      = '0;
        m_axis_c2h_tready = 1'b0;
        irq_ack           = '0;
        irq_ack3          = '0;
        @(negedge user_clk);
        @(negedge user_clk);
        user_rst = 1'b0;
    endtask

    // Send one n-beat packet from source s with the sink always ready.
    task automatic send_pkt(input int s, input int n);
        int b;
        int guard;
        b = 0;
        guard = 0;
        @(negedge user_clk);
        set_src(s, 1'b1, (n == 1), mk_dat(s, 0));
        while (b < n && guard < 40) begin
            #1;
            if (s_axis_tready[s] && s_axis_tvalid[s]) b++;
            @(negedge user_clk);
            guard++;
            if (b < n) set_src(s, 1'b1, (b == n - 1), mk_dat(s, b));
            else       set_src(s, 1'b0, 1'b0, '0);
        end
        checks++;
        if (b != n) begin
            errors++;
            $display("FAIL send_pkt_timeout: src %0d got %0d beats, need %0d", s, b, n);
        end
    endtask

    task automatic test_reset;
        do_reset;
        #1;
        checks++;
        if ({busy, grant_id, m_axis_c2h_tvalid, m_axis_c2h_tlast, s_axis_tready} !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b grant=%0d tvalid=%b tlast=%b tready=%b, need all 0",
                     busy, grant_id, m_axis_c2h_tvalid, m_axis_c2h_tlast, s_axis_tready);
        end
        checks++;
        if ({m_axis_c2h_tdata, m_axis_c2h_tkeep} !== 144'h0) begin
            errors++;
            $display("FAIL reset_data: tdata=%h tkeep=%h, need 0", m_axis_c2h_tdata, m_axis_c2h_tkeep);
        end
        checks++;
        if (irq_req !== 1'b0 || pkt_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_irq_cnt: irq_req=%b pkt_count=%0d, need 0/0", irq_req, pkt_count);
        end
        checks++;
        if ({busy3, grant_id3, m_axis_c2h_tvalid3, m_axis_c2h_tlast3, s_axis_tready3, irq_req3,
             m_axis_c2h_tdata3, m_axis_c2h_tkeep3, pkt_count3} !== '0) begin
            errors++;
            $display("FAIL reset_dut3: busy=%b irq=%b pkt=%0d tdata=%h, need all 0",
                     busy3, irq_req3, pkt_count3, m_axis_c2h_tdata3);
        end
    endtask

    task automatic test_single;
        logic exp_l;
        do_reset;
        m_axis_c2h_tready = 1'b1;
        @(negedge user_clk);
        set_src(0, 1'b1, 1'b0, mk_dat(0, 0));
        #1;
        checks++;
        if (busy !== 1'b0 || s_axis_tready !== 4'b0 || m_axis_c2h_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL single_arb_cycle: busy=%b tready=%b tvalid=%b, need 0/0000/0",
                     busy, s_axis_tready, m_axis_c2h_tvalid);
        end
        for (int b = 0; b < 4; b++) begin
            @(negedge user_clk);
            exp_l = (b == 3);
            set_src(0, 1'b1, exp_l, mk_dat(0, b));
            #1;
            checks++;
            if ({busy, grant_id, m_axis_c2h_tvalid, m_axis_c2h_tlast, s_axis_tready} !==
                {1'b1, 2'd0, 1'b1, exp_l, 4'b0001}) begin
                errors++;
                $display("FAIL single_ctrl beat %0d: busy=%b grant=%0d tvalid=%b tlast=%b tready=%b, need 1/0/1/%b/0001",
                         b, busy, grant_id, m_axis_c2h_tvalid, m_axis_c2h_tlast, s_axis_tready, exp_l);
            end
            checks++;
            if (m_axis_c2h_tdata !== mk_dat(0, b) || m_axis_c2h_tkeep !== 16'hFFFF) begin
                errors++;
                $display("FAIL single_data beat %0d: tdata=%h tkeep=%h, need %h/ffff",
                         b, m_axis_c2h_tdata, m_axis_c2h_tkeep, mk_dat(0, b));
            end
        end
        @(negedge user_clk);
        set_src(0, 1'b0, 1'b0, '0);
        #1;
        checks++;
        if (busy !== 1'b0 || pkt_count !== 32'd1 || irq_req !== 1'b1 || irq_req3 !== 2'b00) begin
            errors++;
            $display("FAIL single_done: busy=%b pkt_count=%0d irq=%b irq3=%b, need 0/1/1/00",
                     busy, pkt_count, irq_req, irq_req3);
        end
    endtask

    task automatic test_round_robin;
        int exp_order [5];
        int beat_of [4];
        int pkt;
        int idle;
        int guard;
        int g;
        exp_order = '{0, 1, 2, 3, 0};
        beat_of   = '{0, 0, 0, 0};
        pkt = 0;
        idle = 0;
        guard = 0;
        do_reset;
        m_axis_c2h_tready = 1'b1;
        while (pkt < 5 && guard < 60) begin
            @(negedge user_clk);
            guard++;
            for (int i = 0; i < 4; i++) set_src(i, 1'b1, (beat_of[i] == 1), mk_dat(i, beat_of[i]));
            #1;
            g = exp_order[pkt];
            if (!busy) begin
                idle++;
                checks++;
                if (m_axis_c2h_tvalid !== 1'b0 || s_axis_tready !== 4'b0) begin
                    errors++;
                    $display("FAIL rr_idle_outputs: tvalid=%b tready=%b, need 0/0000", m_axis_c2h_tvalid, s_axis_tready);
                end
            end else begin
                if (beat_of[g] == 0) begin
                    checks++;
                    if (grant_id !== 2'(g) || idle != 1) begin
                        errors++;
                        $display("FAIL rr_grant pkt %0d: grant=%0d idle_cycles=%0d, need %0d/1", pkt, grant_id, idle, g);
                    end
                    idle = 0;
                end
                checks++;
                if (m_axis_c2h_tdata !== mk_dat(g, beat_of[g]) || m_axis_c2h_tkeep !== mk_keep(g) ||
                    s_axis_tready !== (4'b0001 << g)) begin
                    errors++;
                    $display("FAIL rr_beat pkt %0d: tdata=%h tkeep=%h tready=%b, need %h/%h/%b", pkt,
                             m_axis_c2h_tdata, m_axis_c2h_tkeep, s_axis_tready, mk_dat(g, beat_of[g]),
                             mk_keep(g), 4'b0001 << g);
                end
                if (m_axis_c2h_tvalid && m_axis_c2h_tlast) pkt++;
            end
            for (int i = 0; i < 4; i++) if (s_axis_tready[i]) beat_of[i] = 1 - beat_of[i];
        end
        checks++;
        if (pkt != 5) begin
            errors++;
            $display("FAIL rr_timeout: %0d packets completed, need 5", pkt);
        end
    endtask

    task automatic test_stall;
        do_reset;
        m_axis_c2h_tready = 1'b1;
        @(negedge user_clk);
        set_src(2, 1'b1, 1'b0, mk_dat(2, 0));
        #1;
        @(negedge user_clk);
        set_src(1, 1'b1, 1'b1, mk_dat(1, 0));
        #1;
        checks++;
        if (grant_id !== 2'd2 || m_axis_c2h_tdata !== mk_dat(2, 0) || s_axis_tready !== 4'b0100) begin
            errors++;
            $display("FAIL stall_first: grant=%0d tdata=%h tready=%b, need 2/%h/0100",
                     grant_id, m_axis_c2h_tdata, s_axis_tready, mk_dat(2, 0));
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge user_clk);
            if (c == 0) set_src(2, 1'b1, 1'b1, mk_dat(2, 1));
            m_axis_c2h_tready = 1'b0;
            #1;
            checks++;
            if (m_axis_c2h_tdata !== mk_dat(2, 1) || m_axis_c2h_tvalid !== 1'b1 || m_axis_c2h_tlast !== 1'b1 ||
                s_axis_tready !== 4'b0 || busy !== 1'b1 || grant_id !== 2'd2) begin
                errors++;
                $display("FAIL stall_hold %0d: tdata=%h tvalid=%b tlast=%b tready=%b busy=%b grant=%0d", c,
                         m_axis_c2h_tdata, m_axis_c2h_tvalid, m_axis_c2h_tlast, s_axis_tready, busy, grant_id);
            end
        end
        @(negedge user_clk);
        m_axis_c2h_tready = 1'b1;
        #1;
        checks++;
        if (s_axis_tready !== 4'b0100 || m_axis_c2h_tdata !== mk_dat(2, 1)) begin
            errors++;
            $display("FAIL stall_release: tready=%b tdata=%h, need 0100/%h", s_axis_tready, m_axis_c2h_tdata, mk_dat(2, 1));
        end
        @(negedge user_clk);
        set_src(2, 1'b0, 1'b0, '0);
        #1;
        checks++;
        if (busy !== 1'b0 || pkt_count !== 32'd1 || s_axis_tready !== 4'b0) begin
            errors++;
            $display("FAIL stall_src2_done: busy=%b pkt_count=%0d tready=%b, need 0/1/0000", busy, pkt_count, s_axis_tready);
        end
        @(negedge user_clk);
        #1;
        checks++;
        if (busy !== 1'b1 || grant_id !== 2'd1 || m_axis_c2h_tdata !== mk_dat(1, 0) || s_axis_tready !== 4'b0010) begin
            errors++;
            $display("FAIL stall_src1_next: busy=%b grant=%0d tdata=%h tready=%b, need 1/1/%h/0010",
                     busy, grant_id, m_axis_c2h_tdata, s_axis_tready, mk_dat(1, 0));
        end
        @(negedge user_clk);
        set_src(1, 1'b0, 1'b0, '0);
        #1;
        checks++;
        if (pkt_count !== 32'd2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_src1_done: pkt_count=%0d busy=%b, need 2/0", pkt_count, busy);
        end
    endtask

    task automatic test_irq_coalesce;
        logic exp_irq;
        do_reset;
        m_axis_c2h_tready = 1'b1;
        for (int p = 1; p <= 7; p++) begin
            send_pkt(0, 1);
            #1;
            exp_irq = (p >= 3);
            checks++;
            if (irq_req3 !== {1'b0, exp_irq}) begin
                errors++;
                $display("FAIL irq_coalesce pkt %0d: irq_req=%b, need %b", p, irq_req3, {1'b0, exp_irq});
            end
        end
        @(negedge user_clk);
        irq_ack3 = 2'b01;
        #1;
        @(negedge user_clk);
        irq_ack3 = 2'b00;
        #1;
        checks++;
        if (irq_req3 !== 2'b00) begin
            errors++;
            $display("FAIL irq_ack_clear: irq_req=%b, need 00", irq_req3);
        end
        send_pkt(0, 1);
        #1;
        checks++;
        if (irq_req3 !== 2'b00) begin
            errors++;
            $display("FAIL irq_residual_8: irq_req=%b, need 00", irq_req3);
        end
        send_pkt(0, 1);
        #1;
        checks++;
        if (irq_req3 !== 2'b01 || pkt_count3 !== 32'd9) begin
            errors++;
            $display("FAIL irq_residual_9: irq_req=%b pkt_count=%0d, need 01/9", irq_req3, pkt_count3);
        end
    endtask

    task automatic test_irq_ack_same;
        do_reset;
        m_axis_c2h_tready = 1'b1;
        send_pkt(0, 1);
        #1;
        checks++;
        if (irq_req !== 1'b1) begin
            errors++;
            $display("FAIL irq_first: irq_req=%b, need 1", irq_req);
        end
        @(negedge user_clk);
        set_src(0, 1'b1, 1'b1, mk_dat(0, 9));
        #1;
        @(negedge user_clk);
        irq_ack = 1'b1;
        #1;
        checks++;
        if (m_axis_c2h_tvalid !== 1'b1 || m_axis_c2h_tlast !== 1'b1 || s_axis_tready !== 4'b0001 || irq_req !== 1'b1) begin
            errors++;
            $display("FAIL irq_same_setup: tvalid=%b tlast=%b tready=%b irq=%b, need 1/1/0001/1",
                     m_axis_c2h_tvalid, m_axis_c2h_tlast, s_axis_tready, irq_req);
        end
        @(negedge user_clk);
        irq_ack = 1'b0;
        set_src(0, 1'b0, 1'b0, '0);
        #1;
        checks++;
        if (irq_req !== 1'b1 || pkt_count !== 32'd2) begin
            errors++;
            $display("FAIL irq_event_wins: irq_req=%b pkt_count=%0d, need 1/2", irq_req, pkt_count);
        end
        @(negedge user_clk);
        irq_ack = 1'b1;
        #1;
        @(negedge user_clk);
        irq_ack = 1'b0;
        #1;
        checks++;
        if (irq_req !== 1'b0) begin
            errors++;
            $display("FAIL irq_second_ack: irq_req=%b, need 0", irq_req);
        end
        @(negedge user_clk);
        irq_ack = 1'b1;
        #1;
        @(negedge user_clk);
        irq_ack = 1'b0;
        #1;
        checks++;
        if (irq_req !== 1'b0) begin
            errors++;
            $display("FAIL irq_ack_idle: irq_req=%b, need 0", irq_req);
        end
    endtask

    task automatic test_reset_mid;
        do_reset;
        m_axis_c2h_tready = 1'b1;
        send_pkt(1, 1);
        @(negedge user_clk);
        set_src(0, 1'b1, 1'b0, mk_dat(0, 0));
        #1;
        @(negedge user_clk);
        #1;
        checks++;
        if (busy !== 1'b1 || grant_id !== 2'd0 || m_axis_c2h_tdata !== mk_dat(0, 0)) begin
            errors++;
            $display("FAIL rstmid_beat1: busy=%b grant=%0d tdata=%h, need 1/0/%h", busy, grant_id, m_axis_c2h_tdata, mk_dat(0, 0));
        end
        @(negedge user_clk);
        set_src(0, 1'b1, 1'b0, mk_dat(0, 1));
        set_src(2, 1'b1, 1'b1, mk_dat(2, 0));
        user_rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b1 || m_axis_c2h_tdata !== mk_dat(0, 1)) begin
            errors++;
            $display("FAIL rstmid_beat2: busy=%b tdata=%h, need 1/%h", busy, m_axis_c2h_tdata, mk_dat(0, 1));
        end
        @(negedge user_clk);
        #1;
        checks++;
        if (busy !== 1'b0 || s_axis_tready !== 4'b0 || m_axis_c2h_tvalid !== 1'b0 || m_axis_c2h_tdata !== 128'h0 ||
            pkt_count !== 32'd0 || irq_req !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_cleared: busy=%b tready=%b tvalid=%b tdata=%h pkt=%0d irq=%b, need all 0",
                     busy, s_axis_tready, m_axis_c2h_tvalid, m_axis_c2h_tdata, pkt_count, irq_req);
        end
        @(negedge user_clk);
        user_rst = 1'b0;
        set_src(0, 1'b1, 1'b0, mk_dat(0, 0));
        #1;
        @(negedge user_clk);
        #1;
        checks++;
        if (busy !== 1'b1 || grant_id !== 2'd0 || m_axis_c2h_tdata !== mk_dat(0, 0)) begin
            errors++;
            $display("FAIL rstmid_src0_first: busy=%b grant=%0d tdata=%h, need 1/0/%h",
                     busy, grant_id, m_axis_c2h_tdata, mk_dat(0, 0));
        end
    endtask

    initial begin
        user_rst          = 1'b1;
        s_axis_tdata      = '0;
        s_axis_tkeep      = '0;
        s_axis_tlast      = '0;
        s_axis_tvalid     = '0;
        m_axis_c2h_tready = 1'b0;
        irq_ack           = '0;
        irq_ack3          = '0;
        test_reset;
        test_single;
        test_round_robin;
        test_stall;
        test_irq_coalesce;
        test_irq_ack_same;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
